fifo_ctrl: RTL

//   Pointer/flag controller that turns the 8x4 dual-port RAM (dual_port) into a synchronous FIFO.

---
 rtl/fifo_pkg.sv | 9 +
 rtl/fifo_ptr.sv | 21 ++
 rtl/fifo_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and types for the FIFO pointer/flag controller.
package fifo_pkg;
  localparam int FIFO_DEPTH    = 8;
  localparam int FIFO_AW       = $clog2(FIFO_DEPTH);
  localparam int FIFO_AF_LEVEL = 6;

  typedef logic [FIFO_AW:0]   fifo_cnt_t;
  typedef logic [FIFO_AW-1:0] fifo_ptr_t;
endpackage

// File: rtl/fifo_ptr.sv
// AW-bit wrapping pointer; wraps DEPTH-1 -> 0 by natural rollover.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int AW = FIFO_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  // clr has priority over inc so a flush always lands at slot 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + {{(AW-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller turning an external dual-port RAM into a
// first-word-fall-through synchronous FIFO.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter int AF_LEVEL = FIFO_AF_LEVEL
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic          clr_err,
  output logic          wr_ready,
  output logic          rd_valid,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [AW-1:0] mem_raddr,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_AF   = (AW+1)'(AF_LEVEL);

  logic push_acc, pop_acc;
  logic ovf_set, unf_set;

  // flags decode the registered count, i.e. the state at the start of the cycle
  always_comb begin
    empty       = (count == '0);
    full        = (count == CNT_FULL);
    almost_full = (count >= CNT_AF);
    wr_ready    = ~full;
    rd_valid    = ~empty;
    push_acc    = push & ~full  & ~flush;
    pop_acc     = pop  & ~empty & ~flush;
    ovf_set     = push & full  & ~flush;
    unf_set     = pop  & empty & ~flush;
    // keep the RAM write quiet while reset is held, even with push high
    mem_we      = push_acc & rst_n;
  end

  fifo_ptr #(.AW(AW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (push_acc),
    .ptr   (mem_waddr)
  );

  fifo_ptr #(.AW(AW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (pop_acc),
    .ptr   (mem_raddr)
  );

  // occupancy: simultaneous accepted push+pop leaves it unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     count <= '0;
    else if (flush) count <= '0;
    else begin
      case ({push_acc, pop_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // sticky errors; a new error in the same cycle beats clr_err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_set | (overflow  & ~clr_err);
      underflow <= unf_set | (underflow & ~clr_err);
    end
  end

endmodule
